// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - word-memory initiator with sub-word loads and read-modify-write byte/half stores
module mem_access_ctrl #(
    parameter int MEM_WORDS   = 64,
    parameter bit RANGE_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] ReadData
);
    typedef enum logic [2:0] {IDLE, RD_STB, RD_CAP, WR_STB, RESP} state_t;
    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      state, state_n;
    logic [3:0]  op_q, op_n;
    logic [1:0]  lane_q, lane_n;
    logic [15:0] wlow_q, wlow_n;
    logic [31:0] address_n, write_data_n, rdata_n;
    logic        mem_read_n, mem_write_n, valid_n, err_n;
    logic        req_bad;
    logic [4:0]  shift;
    logic [31:0] shifted, load_val, lane_mask, lane_data, merged;

    assign req_ready = (state == IDLE);

    always_comb begin
        req_bad = 1'b0;
        case (req_op[1:0])
            2'b11:   req_bad = 1'b1;
            2'b10:   req_bad = (req_addr[1:0] != 2'b00);
            2'b01:   req_bad = req_addr[0];
            default: req_bad = 1'b0;
        endcase
        if (RANGE_CHECK && (req_addr[31:2] >= WORD_LIMIT)) begin
            req_bad = 1'b1;
        end
    end

    // One shifter serves both extraction and merge; halfwords shift by 0 or 16.
    always_comb begin
        shift     = (op_q[1:0] == 2'b01) ? {lane_q[1], 4'b0000} : {lane_q, 3'b000};
        shifted   = ReadData >> shift;
        lane_mask = ((op_q[1:0] == 2'b01) ? 32'h0000_FFFF : 32'h0000_00FF) << shift;
        lane_data = {16'h0000, wlow_q} << shift;
        merged    = (ReadData & ~lane_mask) | (lane_data & lane_mask);
        case (op_q[1:0])
            2'b00:   load_val = {{24{shifted[7] & ~op_q[2]}}, shifted[7:0]};
            2'b01:   load_val = {{16{shifted[15] & ~op_q[2]}}, shifted[15:0]};
            default: load_val = ReadData;
        endcase
    end

    always_comb begin
        state_n      = state;
        op_n         = op_q;
        lane_n       = lane_q;
        wlow_n       = wlow_q;
        address_n    = Address;
        write_data_n = WriteData;
        rdata_n      = 32'h0;
        mem_read_n   = 1'b0;
        mem_write_n  = 1'b0;
        valid_n      = 1'b0;
        err_n        = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_n      = req_op;
                    lane_n    = req_addr[1:0];
                    wlow_n    = req_wdata[15:0];
                    address_n = {req_addr[31:2], 2'b00};
                    if (req_bad) begin
                        state_n = RESP;
                        valid_n = 1'b1;
                        err_n   = 1'b1;
                    end else if (req_op[3] && (req_op[1:0] == 2'b10)) begin
                        state_n      = WR_STB;
                        mem_write_n  = 1'b1;
                        write_data_n = req_wdata;
                    end else begin
                        state_n    = RD_STB;
                        mem_read_n = 1'b1;
                    end
                end
            end
            RD_STB: state_n = RD_CAP;
            RD_CAP: begin
                if (op_q[3]) begin
                    state_n      = WR_STB;
                    mem_write_n  = 1'b1;
                    write_data_n = merged;
                end else begin
                    state_n = RESP;
                    valid_n = 1'b1;
                    rdata_n = load_val;
                end
            end
            WR_STB: begin
                state_n = RESP;
                valid_n = 1'b1;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes and response fields are flops so the memory only ever sees clean edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= 4'h0;
            lane_q     <= 2'b00;
            wlow_q     <= 16'h0;
            Address    <= 32'h0;
            WriteData  <= 32'h0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_n;
            op_q       <= op_n;
            lane_q     <= lane_n;
            wlow_q     <= wlow_n;
            Address    <= address_n;
            WriteData  <= write_data_n;
            MemRead    <= mem_read_n;
            MemWrite   <= mem_write_n;
            resp_valid <= valid_n;
            resp_rdata <= rdata_n;
            resp_err   <= err_n;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl with a behavioural word memory
module tb_mem_access_ctrl;
    localparam int MEM_WORDS  = 64;
    localparam int PHYS_WORDS = 128;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        int          xcyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, resp_valid, resp_err, MemWrite, MemRead;
    logic [3:0]  req_op;
    logic [31:0] req_addr, req_wdata, resp_rdata, Address, WriteData;
    logic [31:0] ReadData = 32'h0;
    logic        req_valid_b, req_ready_b, resp_valid_b, resp_err_b, MemWrite_b, MemRead_b;
    logic [3:0]  req_op_b;
    logic [31:0] req_addr_b, req_wdata_b, resp_rdata_b, Address_b, WriteData_b;
    logic [31:0] ReadData_b = 32'h0;

    int          nc = 0, nf = 0, cyc = 0, nresp = 0;
    int          last_resp_cyc = 0, prev_resp_at_xfer = 0, last_xcyc = 0;
    logic [31:0] last_rdata = 32'h0;
    logic        last_err = 1'b0;
    bit          abort_pending = 1'b0;
    exp_t        sbq[$];
    logic [31:0] mem [PHYS_WORDS];
    logic [31:0] ref_mem [PHYS_WORDS];
    logic        init_done = 1'b0, rd_prev = 1'b0, wr_prev = 1'b0, rd_prev_b = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_ctrl #(.MEM_WORDS(MEM_WORDS), .RANGE_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .Address(Address), .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
        .ReadData(ReadData)
    );

    mem_access_ctrl #(.MEM_WORDS(MEM_WORDS), .RANGE_CHECK(1'b0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_op(req_op_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .Address(Address_b), .WriteData(WriteData_b), .MemWrite(MemWrite_b), .MemRead(MemRead_b),
        .ReadData(ReadData_b)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'h8899_AABB;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory acts only on strobe rising edges; read data appears the cycle after MemRead rises.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < PHYS_WORDS; i++) mem[i] <= init_word(i);
            init_done <= 1'b1;
        end else begin
            rd_prev <= MemRead;
            wr_prev <= MemWrite;
            if (MemRead && !rd_prev) ReadData <= mem[Address[8:2]];
            if (MemWrite && !wr_prev) mem[Address[8:2]] <= WriteData;
        end
        rd_prev_b <= MemRead_b;
        if (MemRead_b && !rd_prev_b) ReadData_b <= init_word(int'(Address_b[8:2]));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        nc++;
        if (act !== expv) begin
            nf++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic ref_model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                             output exp_t e);
        int unsigned idx, lane, size;
        logic [7:0]  b [4];
        logic [15:0] h;
        logic [31:0] w;
        idx  = addr / 4;
        lane = addr % 4;
        size = 32'(op[1:0]);
        e.op = op; e.addr = addr; e.rdata = 32'h0; e.err = 1'b0;
        e.lat = 1; e.nrd = 0; e.nwr = 0; e.xcyc = 0;
        if (size == 3 || (size == 2 && lane != 0) || (size == 1 && lane % 2 != 0) || idx >= MEM_WORDS) begin
            e.err = 1'b1;
            return;
        end
        w = ref_mem[idx];
        for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
        if (!op[3]) begin
            e.nrd = 1;
            e.lat = 3;
            if (size == 2) e.rdata = w;
            else if (size == 0) e.rdata = (op[2] || b[lane] < 128) ? 32'(b[lane]) : 32'(b[lane]) + 32'hFFFF_FF00;
            else begin
                h = {b[lane+1], b[lane]};
                e.rdata = (op[2] || h < 16'h8000) ? 32'(h) : 32'(h) + 32'hFFFF_0000;
            end
        end else begin
            e.nwr = 1;
            if (size == 2) begin
                e.lat = 2;
                ref_mem[idx] = wd;
            end else begin
                e.nrd = 1;
                e.lat = 4;
                b[lane] = wd[7:0];
                if (size == 1) b[lane+1] = wd[15:8];
                ref_mem[idx] = {b[3], b[2], b[1], b[0]};
            end
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input bit hold, input bit track);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {31'h0, req_ready}, 32'h1);
        prev_resp_at_xfer = last_resp_cyc;
        last_xcyc = cyc + 1;
        @(posedge clk);
        if (track) begin
            ref_model(op, addr, wd, e);
            e.xcyc = last_xcyc;
            sbq.push_back(e);
        end
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("resp_timeout_pending", 32'(sbq.size()), 32'h0);
        @(negedge clk);
    endtask

    task automatic run1(input string nm, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] expv, input logic experr);
        issue(op, addr, wd, 1'b0, 1'b1);
        wait_idle();
        chk(nm, last_rdata, expv);
        chk({nm, "_err"}, {31'h0, last_err}, {31'h0, experr});
    endtask

    initial begin : monitor
        exp_t e;
        int   nrd = 0, nwr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nrd = 0;
                nwr = 0;
            end else begin
                if (MemRead) nrd++;
                if (MemWrite) nwr++;
                chk("strobe_overlap", {31'h0, MemRead & MemWrite}, 32'h0);
                if (!abort_pending)
                    chk("req_ready", {31'h0, req_ready}, {31'h0, sbq.size() == 0});
                if (resp_valid) begin
                    nresp++;
                    if (sbq.size() == 0) begin
                        chk("unexpected_resp", 32'h1, 32'h0);
                    end else begin
                        e = sbq.pop_front();
                        chk($sformatf("rdata op=%h addr=%h", e.op, e.addr), resp_rdata, e.rdata);
                        chk($sformatf("err op=%h addr=%h", e.op, e.addr), {31'h0, resp_err}, {31'h0, e.err});
                        chk($sformatf("latency op=%h addr=%h", e.op, e.addr), 32'(cyc - e.xcyc + 1), 32'(e.lat));
                        chk($sformatf("reads op=%h addr=%h", e.op, e.addr), 32'(nrd), 32'(e.nrd));
                        chk($sformatf("writes op=%h addr=%h", e.op, e.addr), 32'(nwr), 32'(e.nwr));
                    end
                    last_rdata = resp_rdata;
                    last_err = resp_err;
                    last_resp_cyc = cyc;
                    nrd = 0;
                    nwr = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          r, n, got, rd_seen, resp_before;
        logic [1:0]  size;
        logic [3:0]  op;
        logic [31:0] a;
        bit          hold;
        req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
        req_valid_b = 1'b0; req_op_b = 4'b0010; req_addr_b = 32'h100; req_wdata_b = 32'h0;
        for (int i = 0; i < PHYS_WORDS; i++) ref_mem[i] = init_word(i);
        repeat (3) @(negedge clk);
        chk("rst_address", Address, 32'h0);
        chk("rst_wdata", WriteData, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_flags", {28'h0, MemRead, MemWrite, resp_valid, resp_err}, 32'h0);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        rst_n = 1'b1;
        @(negedge clk);

        run1("lw_4",  4'b0010, 32'h4, 32'h0, 32'h8899_AABB, 1'b0);
        run1("lb_7",  4'b0000, 32'h7, 32'h0, 32'hFFFF_FF88, 1'b0);
        run1("lbu_7", 4'b0100, 32'h7, 32'h0, 32'h0000_0088, 1'b0);
        run1("lh_6",  4'b0001, 32'h6, 32'h0, 32'hFFFF_8899, 1'b0);
        run1("lhu_4", 4'b0101, 32'h4, 32'h0, 32'h0000_AABB, 1'b0);
        run1("sb_5",  4'b1000, 32'h5, 32'h1234_56CC, 32'h0, 1'b0);
        chk("sb_5_mem", mem[1], 32'h8899_CCBB);
        run1("lw_4_after_sb", 4'b0010, 32'h4, 32'h0, 32'h8899_CCBB, 1'b0);
        run1("sw_2_misaligned", 4'b1010, 32'h2,   32'h1, 32'h0, 1'b1);
        run1("lh_5_misaligned", 4'b0001, 32'h5,   32'h0, 32'h0, 1'b1);
        run1("size_reserved",   4'b0011, 32'h0,   32'h0, 32'h0, 1'b1);
        run1("lw_out_of_range", 4'b0010, 32'h100, 32'h0, 32'h0, 1'b1);

        issue(4'b1010, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        issue(4'b0010, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("b2b_transfer_gap", 32'(last_xcyc - prev_resp_at_xfer), 32'd2);
        wait_idle();
        chk("b2b_lw", last_rdata, 32'hDEAD_BEEF);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            size = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            op = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), size};
            a = 32'($urandom_range(0, MEM_WORDS * 4 + 7));
            if ($urandom_range(0, 7) != 0)
                a = a & ~((size == 2'd2) ? 32'h3 : (size == 2'd1) ? 32'h1 : 32'h0);
            hold = 1'($urandom_range(0, 1));
            issue(op, a, $urandom(), hold, 1'b1);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req_valid = 1'b0;
        wait_idle();

        abort_pending = 1'b1;
        resp_before = nresp;
        issue(4'b1001, 32'h6, 32'h0000_7777, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_address", Address, 32'h0);
        chk("abort_wdata", WriteData, 32'h0);
        chk("abort_flags", {28'h0, MemRead, MemWrite, resp_valid, resp_err}, 32'h0);
        chk("abort_rdata", resp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_resp", 32'(nresp - resp_before), 32'h0);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_mem", mem[1], ref_mem[1]);
        abort_pending = 1'b0;

        @(negedge clk);
        req_valid_b = 1'b1;
        @(posedge clk);
        #1 req_valid_b = 1'b0;
        n = 0; got = 0; rd_seen = 0;
        while (n < 12 && got == 0) begin
            @(negedge clk);
            if (MemRead_b) rd_seen++;
            if (resp_valid_b) begin
                got = 1;
                chk("nr_lw_100", resp_rdata_b, init_word(64));
                chk("nr_lw_100_err", {31'h0, resp_err_b}, 32'h0);
            end
            n++;
        end
        chk("nr_resp_seen", 32'(got), 32'h1);
        chk("nr_read_strobes", 32'(rd_seen), 32'h1);

        repeat (3) @(negedge clk);
        for (int i = 0; i < MEM_WORDS; i++) chk($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end
endmodule
